// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extender arbiter: extender Ctrl codes,
// opcode match patterns, FSM encoding and the round-robin pick helper.
package imm_ext_pkg;

  localparam int INSTR_W = 32;
  localparam int DATA_W  = 64;

  localparam logic [2:0] CTRL_I    = 3'b000;
  localparam logic [2:0] CTRL_D    = 3'b001;
  localparam logic [2:0] CTRL_CB   = 3'b010;
  localparam logic [2:0] CTRL_B    = 3'b011;
  localparam logic [2:0] CTRL_MOVZ = 3'b100;

  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [6:0]  OP_CB   = 7'b1011010;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [9:0]  OP_ANDI = 10'b1001001000;
  localparam logic [9:0]  OP_ORRI = 10'b1011001000;
  localparam logic [8:0]  OP_MOVZ = 9'b110100101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXT  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Returns 1 when requester 1 wins; on a tie the side that did not win last time goes.
  function automatic logic rr_pick1(input logic v0, input logic v1, input logic last);
    return (v0 && v1) ? ~last : v1;
  endfunction

endpackage

// File: rtl/imm_class_decode.sv
// Combinational immediate-class decode from instr[31:21] to extender Ctrl.
// Unrecognised opcodes report illegal and fall back to the I-type Ctrl.
module imm_class_decode
  import imm_ext_pkg::*;
(
  input  logic [10:0] opfield_i,
  output logic [2:0]  ctrl_o,
  output logic        illegal_o
);

  always_comb begin
    ctrl_o    = CTRL_I;
    illegal_o = 1'b0;
    if (opfield_i[10:5] == OP_B) begin
      ctrl_o = CTRL_B;
    end else if (opfield_i[10:4] == OP_CB) begin
      ctrl_o = CTRL_CB;
    end else if ((opfield_i == OP_LDUR) || (opfield_i == OP_STUR)) begin
      ctrl_o = CTRL_D;
    end else if ((opfield_i[10:1] == OP_ADDI) || (opfield_i[10:1] == OP_SUBI) ||
                 (opfield_i[10:1] == OP_ANDI) || (opfield_i[10:1] == OP_ORRI)) begin
      ctrl_o = CTRL_I;
    end else if (opfield_i[10:2] == OP_MOVZ) begin
      ctrl_o = CTRL_MOVZ;
    end else begin
      illegal_o = 1'b1;
    end
  end

endmodule

// File: rtl/imm_ext_arbiter.sv
// Round-robin, one-in-flight arbiter sharing the immediate sign extender between
// two requesters. Optional IMM_BR_SHIFT_EN turns branch offsets into byte offsets.
//
// Handshake: a request transfers on the cycle reqN_valid && reqN_ready; ready is
// only raised in IDLE for the granted, valid requester. A response transfers on
// rsp_valid && rsp_ready, and rsp_* stay stable while rsp_valid waits for ready.
module imm_ext_arbiter
  import imm_ext_pkg::*;
#(
  parameter int unsigned ERR_ON_ILLEGAL = 1
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [INSTR_W-1:0] req0_instr,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [INSTR_W-1:0] req1_instr,
  output logic [25:0]        ext_imm26,
  output logic [2:0]         ext_ctrl,
  input  logic [DATA_W-1:0]  ext_busimm,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [DATA_W-1:0]  rsp_imm,
  output logic               rsp_err,
  output state_e             dbg_state_o
);

  state_e              state_q, state_d;
  logic                last_grant_q;
  logic [25:0]         ext_imm26_q;
  logic [2:0]          ext_ctrl_q;
  logic                id_q, err_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_imm_q;

  logic                any_valid, grant1, accept;
  logic [INSTR_W-1:0]  sel_instr;
  logic [2:0]          dec_ctrl;
  logic                dec_illegal;
  logic [DATA_W-1:0]   ext_result;

  assign any_valid = req0_valid || req1_valid;
  assign grant1    = rr_pick1(req0_valid, req1_valid, last_grant_q);
  assign accept    = (state_q == ST_IDLE) && any_valid;
  assign sel_instr = grant1 ? req1_instr : req0_instr;

  imm_class_decode u_decode (
    .opfield_i (sel_instr[31:21]),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal)
  );

`ifdef IMM_BR_SHIFT_EN
  assign ext_result = ((ext_ctrl_q == CTRL_B) || (ext_ctrl_q == CTRL_CB)) ?
                      (ext_busimm << 2) : ext_busimm;
`else
  assign ext_result = ext_busimm;
`endif

  always_ff @(posedge CLK) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXT;
      ST_EXT:  state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req0_ready  = accept && !grant1;
    req1_ready  = accept && grant1;
    dbg_state_o = state_q;
  end

  // The extender output is sampled only at the end of EXT, after a full settle cycle.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      ext_imm26_q  <= '0;
      ext_ctrl_q   <= CTRL_I;
      id_q         <= 1'b0;
      err_q        <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_imm_q    <= '0;
    end else begin
      if (accept) begin
        ext_imm26_q  <= sel_instr[25:0];
        ext_ctrl_q   <= dec_ctrl;
        id_q         <= grant1;
        err_q        <= dec_illegal && (ERR_ON_ILLEGAL != 0);
        last_grant_q <= grant1;
      end
      if (state_q == ST_EXT) begin
        rsp_valid_q <= 1'b1;
        rsp_imm_q   <= err_q ? '0 : ext_result;
      end else if ((state_q == ST_RESP) && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign ext_imm26 = ext_imm26_q;
  assign ext_ctrl  = ext_ctrl_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_imm   = rsp_imm_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Testbench for imm_ext_arbiter: directed vectors with literal expectations plus a
// cycle-level reference model (timeline of accept/response) checked every cycle.
module tb_imm_ext_arbiter;
  import imm_ext_pkg::*;

  localparam int ERR = 1;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_instr = '0, req1_instr = '0;
  logic [25:0] ext_imm26;
  logic [2:0]  ext_ctrl;
  logic [63:0] ext_busimm;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_err;
  logic [63:0] rsp_imm;
  state_e      dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  imm_ext_arbiter #(.ERR_ON_ILLEGAL(ERR)) dut (
    .CLK(CLK), .Reset(Reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_instr(req0_instr),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_instr(req1_instr),
    .ext_imm26(ext_imm26), .ext_ctrl(ext_ctrl), .ext_busimm(ext_busimm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_imm(rsp_imm), .rsp_err(rsp_err), .dbg_state_o(dbg_state)
  );

  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // Extender behaviour, as seen by the arbiter.
  function automatic logic [63:0] ext_model(input logic [25:0] i, input logic [2:0] c);
    logic [63:0] mv;
    case (c)
      3'b000:  return {52'b0, i[21:10]};
      3'b001:  return {{55{i[20]}}, i[20:12]};
      3'b010:  return {{45{i[23]}}, i[23:5]};
      3'b011:  return {{38{i[25]}}, i[25:0]};
      3'b100: begin
        mv = {48'b0, i[20:5]};
        return mv << (16 * int'(i[22:21]));
      end
      default: return '0;
    endcase
  endfunction

  assign ext_busimm = ext_model(ext_imm26, ext_ctrl);

  function automatic int spec_class(input logic [31:0] w);
    if (w[31:26] == 6'b000101) return 3;
    if (w[31:25] == 7'b1011010) return 2;
    if (w[31:21] inside {11'b11111000010, 11'b11111000000}) return 1;
    if (w[31:22] inside {10'b1001000100, 10'b1101000100, 10'b1001001000, 10'b1011001000}) return 0;
    if (w[31:23] == 9'b110100101) return 4;
    return -1;
  endfunction

  function automatic logic [2:0] spec_ctrl(input logic [31:0] w);
    int c;
    c = spec_class(w);
    return (c < 0) ? 3'd0 : 3'(c);
  endfunction

  function automatic logic spec_err(input logic [31:0] w);
    return (spec_class(w) < 0) && (ERR != 0);
  endfunction

  function automatic logic [63:0] spec_imm(input logic [31:0] w);
    logic [63:0] v;
    if (spec_err(w)) return '0;
    v = ext_model(w[25:0], spec_ctrl(w));
`ifdef IMM_BR_SHIFT_EN
    if (spec_ctrl(w) inside {3'd2, 3'd3}) v = v * 64'd4;
`endif
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Reference model: one pending transaction, response due two cycles after accept.
  int          cyc = 0;
  bit          m_busy = 1'b0;
  bit          m_last = 1'b1;
  int          m_acc = 0;
  bit          m_id = 1'b0;
  logic [31:0] m_w = '0;
  int          acc_cyc_q[$];
  int          acc_id_q[$];

  always @(negedge CLK) begin
    bit e_rdy0, e_rdy1, e_rv, g1;
    e_rdy0 = !m_busy && req0_valid && (!req1_valid || m_last);
    e_rdy1 = !m_busy && req1_valid && (!req0_valid || !m_last);
    e_rv   = m_busy && (cyc >= m_acc + 2);
    if (chk_en) begin
      chk("model req0_ready", req0_ready, e_rdy0);
      chk("model req1_ready", req1_ready, e_rdy1);
      chk("model rsp_valid", rsp_valid, e_rv);
      if (m_busy && cyc >= m_acc + 1) begin
        chk("model ext_imm26", ext_imm26, m_w[25:0]);
        chk("model ext_ctrl", ext_ctrl, spec_ctrl(m_w));
      end
      if (e_rv) begin
        chk("model rsp_id", rsp_id, m_id);
        chk("model rsp_imm", rsp_imm, spec_imm(m_w));
        chk("model rsp_err", rsp_err, spec_err(m_w));
      end
    end
    if (Reset) begin
      m_busy = 1'b0;
      m_last = 1'b1;
    end else if (e_rv && rsp_ready) begin
      m_busy = 1'b0;
    end else if (!m_busy && (req0_valid || req1_valid)) begin
      g1     = e_rdy1;
      m_busy = 1'b1;
      m_acc  = cyc;
      m_id   = g1;
      m_last = g1;
      m_w    = g1 ? req1_instr : req0_instr;
      acc_cyc_q.push_back(cyc);
      acc_id_q.push_back(int'(g1));
    end
    cyc++;
  end

  task automatic do_reset();
    @(posedge CLK); #1;
    Reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1 Reset = 1'b0;
  endtask

  task automatic run_one(input string nm, input bit port, input logic [31:0] w,
                         input logic [2:0] e_ctrl, input logic [63:0] e_imm, input bit e_err);
    int waited;
    bit got;
    @(posedge CLK); #1;
    if (port) begin req1_valid = 1'b1; req1_instr = w; end
    else      begin req0_valid = 1'b1; req0_instr = w; end
    waited = 0; got = 1'b0;
    while (!got && waited < 20) begin
      @(negedge CLK);
      got = port ? req1_ready : req0_ready;
      waited++;
    end
    chk({nm, " accept"}, got, 1'b1);
    chk({nm, " accept cycle"}, waited, 1);
    @(posedge CLK); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge CLK);
    chk({nm, " ext_ctrl"}, ext_ctrl, e_ctrl);
    chk({nm, " rsp_valid in EXT"}, rsp_valid, 1'b0);
    @(negedge CLK);
    chk({nm, " rsp_valid"}, rsp_valid, 1'b1);
    chk({nm, " rsp_id"}, rsp_id, port);
    chk({nm, " rsp_imm"}, rsp_imm, e_imm);
    chk({nm, " rsp_err"}, rsp_err, e_err);
    @(posedge CLK); #1;
  endtask

  task automatic drain();
    repeat (6) @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [63:0] held;
    int waited;

    do_reset();
    chk_en = 1'b1;
    @(negedge CLK);
    chk("reset rsp_valid", rsp_valid, 1'b0);
    chk("reset rsp_id", rsp_id, 1'b0);
    chk("reset rsp_err", rsp_err, 1'b0);
    chk("reset rsp_imm", rsp_imm, 64'd0);
    chk("reset ext_imm26", ext_imm26, 26'd0);
    chk("reset ext_ctrl", ext_ctrl, 3'b000);
    chk("reset state", dbg_state, ST_IDLE);

    run_one("addi", 1'b0, 32'h91002820, 3'b000, 64'h000000000000000A, 1'b0);
`ifdef IMM_BR_SHIFT_EN
    run_one("b", 1'b1, 32'h17FFFFFF, 3'b011, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    run_one("cbz", 1'b0, 32'hB4FFFFC3, 3'b010, 64'hFFFFFFFFFFFFFFF8, 1'b0);
`else
    run_one("b", 1'b1, 32'h17FFFFFF, 3'b011, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    run_one("cbz", 1'b0, 32'hB4FFFFC3, 3'b010, 64'hFFFFFFFFFFFFFFFE, 1'b0);
`endif
    run_one("movz", 1'b0, 32'hD2A24680, 3'b100, 64'h0000000012340000, 1'b0);
    run_one("illegal0", 1'b0, 32'h00000000, 3'b000, 64'd0, 1'b1);
    run_one("illegal_c00", 1'b0, 32'h00000C00, 3'b000, 64'd0, 1'b1);
    run_one("ldur", 1'b1, 32'hF85F8041, 3'b001, 64'hFFFFFFFFFFFFFFF8, 1'b0);
    run_one("stur", 1'b1, 32'hF81F8041, 3'b001, 64'hFFFFFFFFFFFFFFF8, 1'b0);
    run_one("subi", 1'b1, 32'hD1000400, 3'b000, 64'h0000000000000001, 1'b0);

    // Both requesters valid continuously from reset: grants alternate, 3 cycles apart.
    do_reset();
    acc_cyc_q.delete(); acc_id_q.delete();
    req0_instr = 32'h91002820; req1_instr = 32'h17FFFFFF;
    req0_valid = 1'b1; req1_valid = 1'b1;
    waited = 0;
    while (acc_id_q.size() < 4 && waited < 40) begin
      @(negedge CLK); #1;
      waited++;
    end
    @(posedge CLK); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr grant count", acc_id_q.size(), 4);
    if (acc_id_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("rr id[%0d]", i), acc_id_q[i], i % 2);
        if (i > 0) chk($sformatf("rr spacing[%0d]", i), acc_cyc_q[i] - acc_cyc_q[i-1], 3);
      end
    end
    drain();

    // Back-pressure in RESP, then reset while the response is still pending.
    rsp_ready = 1'b0;
    req0_instr = 32'hD2A24680; req0_valid = 1'b1;
    @(posedge CLK); #1;
    req0_instr = 32'h91002820; req1_valid = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    held = rsp_imm;
    chk("stall rsp_imm", held, 64'h0000000012340000);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("stall rsp_valid", rsp_valid, 1'b1);
      chk("stall rsp_imm stable", rsp_imm, held);
      chk("stall req0_ready", req0_ready, 1'b0);
      chk("stall req1_ready", req1_ready, 1'b0);
    end
    @(posedge CLK); #1;
    Reset = 1'b1;
    @(posedge CLK); #1;
    Reset = 1'b0;
    acc_id_q.delete();
    @(negedge CLK);
    chk("post-reset rsp_valid", rsp_valid, 1'b0);
    chk("post-reset state", dbg_state, ST_IDLE);
    chk("post-reset rsp_imm", rsp_imm, 64'd0);
    chk("post-reset req0_ready", req0_ready, 1'b1);
    #1;
    chk("post-reset first grant id", (acc_id_q.size() > 0) ? acc_id_q[0] : -1, 0);
    @(posedge CLK); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
